viterbi_traceback: RTL and testbench

Traceback/decision unit of the Viterbi decoder; the consumer end of the CONTROL interface.
- Runs entirely on Clock1.
- On each TB_EN request it walks the survivor-decision memory backwards TB_LEN pages, starting from the current minimum-metric state.
- Emits one decoded bit per request.
- Handles warm-up (no output until the trellis is TB_LEN pages deep), page wrap-around and overrun detection.

---
 rtl/viterbi_traceback_pkg.sv | 16 +
 rtl/viterbi_traceback.sv | 124 ++++++++++++
 tb/tb_viterbi_traceback.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_traceback_pkg.sv
// Shared defaults and FSM encoding for the Viterbi traceback unit.
package viterbi_traceback_pkg;

    localparam int DEF_WD_FSM   = 6;
    localparam int DEF_WD_DEPTH = 5;
    localparam int DEF_WD_STATE = 6;
    localparam int DEF_TB_LEN   = 30;

    typedef enum logic [1:0] {
        TB_IDLE = 2'd0,
        TB_RD   = 2'd1,
        TB_DATA = 2'd2,
        TB_OUT  = 2'd3
    } tb_state_e;

endpackage

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: per request, walks TB_LEN survivor pages backwards from the
// minimum-metric state and emits one decoded bit.
module viterbi_traceback
    import viterbi_traceback_pkg::*;
#(
    parameter int WD_FSM   = DEF_WD_FSM,
    parameter int WD_DEPTH = DEF_WD_DEPTH,
    parameter int WD_STATE = DEF_WD_STATE,
    parameter int TB_LEN   = DEF_TB_LEN
) (
    input  logic                         Clock1,
    input  logic                         Reset,
    input  logic                         Active,
    input  logic                         TB_EN,
    input  logic [WD_DEPTH-1:0]          ACSPage,
    input  logic [WD_STATE-1:0]          LowestState,
    output logic                         MemRdEn,
    output logic [WD_DEPTH+WD_STATE-1:0] MemRdAddr,
    input  logic                         MemRdData,
    output logic                         DecodedBit,
    output logic                         DecodeValid,
    output logic                         Busy,
    output logic                         TbOverrun
);

    localparam int WD_FILL = $clog2(TB_LEN + 1);
    localparam int WD_STEP = (TB_LEN > 1) ? $clog2(TB_LEN) : 1;
    localparam logic [WD_FILL-1:0] FILL_MAX  = WD_FILL'(TB_LEN);
    localparam logic [WD_STEP-1:0] STEP_LAST = WD_STEP'(TB_LEN - 1);
    localparam bit CFG_OK = (TB_LEN <= (2**WD_DEPTH) - 1) && (2*TB_LEN + 2 <= 2**WD_FSM);

    // A traceback must finish inside one page, otherwise every request overruns.
    if (!CFG_OK) begin : g_bad_cfg
        $error("viterbi_traceback: TB_LEN does not fit WD_DEPTH/WD_FSM");
    end

    tb_state_e             state_q, state_d;
    logic [WD_DEPTH-1:0]   page_q, page_d;
    logic [WD_STATE-1:0]   cstate_q, cstate_d;
    logic [WD_STEP-1:0]    step_q, step_d;
    logic [WD_FILL-1:0]    fill_q, fill_d;
    logic                  overrun_q, overrun_d;
    logic                  bit_q, bit_d;

    always_ff @(posedge Clock1 or negedge Reset) begin
        if (!Reset) begin
            state_q   <= TB_IDLE;
            page_q    <= '0;
            cstate_q  <= '0;
            step_q    <= '0;
            fill_q    <= '0;
            overrun_q <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            cstate_q  <= cstate_d;
            step_q    <= step_d;
            fill_q    <= fill_d;
            overrun_q <= overrun_d;
            bit_q     <= bit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        cstate_d  = cstate_q;
        step_d    = step_q;
        fill_d    = fill_q;
        overrun_d = overrun_q;
        bit_d     = bit_q;

        case (state_q)
            TB_IDLE: begin
                if (TB_EN) begin
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + WD_FILL'(1);
                    end else begin
                        page_d   = ACSPage;
                        cstate_d = LowestState;
                        step_d   = '0;
                        state_d  = TB_RD;
                    end
                end
            end
            TB_RD: state_d = TB_DATA;
            TB_DATA: begin
                cstate_d = {cstate_q[WD_STATE-2:0], MemRdData};
                page_d   = page_q - WD_DEPTH'(1);
                step_d   = step_q + WD_STEP'(1);
                if (step_q == STEP_LAST) begin
                    state_d = TB_OUT;
                    bit_d   = cstate_d[WD_STATE-1];
                end else begin
                    state_d = TB_RD;
                end
            end
            TB_OUT: state_d = TB_IDLE;
            default: state_d = TB_IDLE;
        endcase

        if (TB_EN && state_q != TB_IDLE) overrun_d = 1'b1;

        // Abort wins over everything; TB_EN is ignored while inactive.
        if (!Active) begin
            state_d   = TB_IDLE;
            fill_d    = '0;
            page_d    = page_q;
            cstate_d  = cstate_q;
            step_d    = step_q;
            overrun_d = overrun_q;
            bit_d     = bit_q;
        end
    end

    assign MemRdEn     = (state_q == TB_RD);
    assign MemRdAddr   = {page_q, cstate_q};
    assign DecodeValid = (state_q == TB_OUT);
    assign DecodedBit  = bit_q;
    assign Busy        = (state_q != TB_IDLE);
    assign TbOverrun   = overrun_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Scoreboard bench for viterbi_traceback: directed runs queue expected bit and
// strobe cycle; a monitor checks every DecodeValid against the queue.
module tb_viterbi_traceback;

    localparam int WD_DEPTH = 5;
    localparam int WD_STATE = 6;
    localparam int TB_LEN   = 30;
    localparam int AW       = WD_DEPTH + WD_STATE;

    logic                Clock1 = 1'b0;
    logic                Reset, Active, TB_EN;
    logic [WD_DEPTH-1:0] ACSPage;
    logic [WD_STATE-1:0] LowestState;
    logic                MemRdEn;
    logic [AW-1:0]       MemRdAddr;
    logic                MemRdData;
    logic                DecodedBit, DecodeValid, Busy, TbOverrun;

    viterbi_traceback dut (
        .Clock1(Clock1), .Reset(Reset), .Active(Active), .TB_EN(TB_EN),
        .ACSPage(ACSPage), .LowestState(LowestState),
        .MemRdEn(MemRdEn), .MemRdAddr(MemRdAddr), .MemRdData(MemRdData),
        .DecodedBit(DecodedBit), .DecodeValid(DecodeValid),
        .Busy(Busy), .TbOverrun(TbOverrun)
    );

    always #5 Clock1 = ~Clock1;

    typedef struct { logic b; int cyc; } exp_t;
    exp_t          sb[$];
    logic [AW-1:0] obs_addr[$];
    logic [AW-1:0] exp_addr[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            rd_total = 0;
    logic [1:0]    mem_mode = 2'd0;

    function automatic logic mem_fn(input logic [1:0] mode, input logic [AW-1:0] a);
        case (mode)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            default: return ^(a & 11'h4B5);
        endcase
    endfunction

    // Decision memory: one cycle read latency.
    always @(posedge Clock1 or negedge Reset) begin
        if (!Reset)       MemRdData <= 1'b0;
        else if (MemRdEn) MemRdData <= mem_fn(mem_mode, MemRdAddr);
    end

    always @(posedge Clock1) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    always @(negedge Clock1) begin
        if (Reset && MemRdEn) begin
            obs_addr.push_back(MemRdAddr);
            rd_total++;
        end
        if (Reset && DecodeValid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_decode_valid: got DecodeValid=1 bit=%0b, want none", DecodedBit);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("decoded_bit", 32'(DecodedBit), 32'(e.b));
                check("decode_latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge Clock1);
    endtask

    // One-cycle TB_EN; returns the cycle number of the sampling edge.
    task automatic pulse(input logic [WD_DEPTH-1:0] p, input logic [WD_STATE-1:0] s, output int c);
        @(negedge Clock1);
        ACSPage = p; LowestState = s; TB_EN = 1'b1;
        @(negedge Clock1);
        TB_EN = 1'b0;
        c = cyc;
    endtask

    task automatic issue(input logic [WD_DEPTH-1:0] p, input logic [WD_STATE-1:0] s, input logic b);
        int   c;
        exp_t e;
        pulse(p, s, c);
        e.b = b;
        e.cyc = c + 2*TB_LEN;
        sb.push_back(e);
    endtask

    // Reference walk for a given memory mode; fills exp_addr, returns decoded bit.
    task automatic model(input logic [WD_DEPTH-1:0] p, input logic [WD_STATE-1:0] s, output logic b);
        logic [WD_DEPTH-1:0] pg;
        logic [WD_STATE-1:0] st;
        pg = p; st = s;
        exp_addr.delete();
        for (int k = 0; k < TB_LEN; k++) begin
            exp_addr.push_back({pg, st});
            st = {st[WD_STATE-2:0], mem_fn(mem_mode, {pg, st})};
            pg = pg - 1'b1;
        end
        b = st[WD_STATE-1];
    endtask

    task automatic check_addrs(input string nm);
        check({nm, "_count"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
            check(nm, 32'(obs_addr[i]), 32'(exp_addr[i]));
    endtask

    initial begin
        int   c, rd0;
        logic eb;
        Reset = 1'b0; Active = 1'b0; TB_EN = 1'b0; ACSPage = '0; LowestState = '0;
        #12;
        check("rst_busy", 32'(Busy), 0);
        check("rst_rden", 32'(MemRdEn), 0);
        check("rst_addr", 32'(MemRdAddr), 0);
        check("rst_valid", 32'(DecodeValid), 0);
        check("rst_bit", 32'(DecodedBit), 0);
        check("rst_overrun", 32'(TbOverrun), 0);
        Reset = 1'b1;
        wait_n(2);
        Active = 1'b1;

        // Warm-up: 30 requests are absorbed without reads.
        for (int i = 0; i < TB_LEN; i++) begin
            pulse(5'(i), 6'(i), c);
            wait_n(62);
        end
        check("warmup_reads", rd_total, 0);
        check("warmup_busy", 32'(Busy), 0);

        // 31st request, all-zero decisions.
        mem_mode = 2'd0;
        issue(5'd7, 6'h3F, 1'b0);
        check("start_busy", 32'(Busy), 1);
        wait_n(70);
        check("run0_reads", rd_total, TB_LEN);

        // Address sequence with all-one decisions.
        mem_mode = 2'd1;
        obs_addr.delete();
        issue(5'd3, 6'h2A, 1'b1);
        wait_n(70);
        check("addr0", 32'(obs_addr[0]), 32'({5'd3, 6'h2A}));
        check("addr1", 32'(obs_addr[1]), 32'({5'd2, 6'h15}));
        check("addr2", 32'(obs_addr[2]), 32'({5'd1, 6'h2B}));
        check("addr_last_page", 32'(obs_addr[TB_LEN-1][AW-1:WD_STATE]), 32'(5'd6));
        check("addr_count", obs_addr.size(), TB_LEN);

        // Page wrap with data-dependent decisions.
        mem_mode = 2'd2;
        obs_addr.delete();
        model(5'd1, 6'h11, eb);
        issue(5'd1, 6'h11, eb);
        wait_n(70);
        check("wrap_page2", 32'(obs_addr[2][AW-1:WD_STATE]), 32'(5'd31));
        check_addrs("wrap_addr");

        // Overrun: second request mid-run is dropped.
        mem_mode = 2'd1;
        check("pre_overrun", 32'(TbOverrun), 0);
        obs_addr.delete();
        mem_mode = 2'd2;
        model(5'd10, 6'h05, eb);
        issue(5'd10, 6'h05, eb);
        wait_n(18);
        pulse(5'd20, 6'h30, c);
        check("overrun_set", 32'(TbOverrun), 1);
        wait_n(60);
        check_addrs("overrun_addr");
        check("overrun_sticky", 32'(TbOverrun), 1);
        check("overrun_sb_empty", sb.size(), 0);

        // Abort mid-traceback after a run that left DecodedBit=1.
        mem_mode = 2'd1;
        issue(5'd4, 6'h00, 1'b1);
        wait_n(70);
        pulse(5'd9, 6'h01, c);
        wait_n(10);
        Active = 1'b0;
        wait_n(1);
        check("abort_busy", 32'(Busy), 0);
        check("abort_rden", 32'(MemRdEn), 0);
        check("abort_overrun_kept", 32'(TbOverrun), 1);
        check("abort_bit_kept", 32'(DecodedBit), 1);
        pulse(5'd9, 6'h01, c);
        wait_n(70);
        check("inactive_busy", 32'(Busy), 0);
        Active = 1'b1;
        rd0 = rd_total;
        for (int i = 0; i < TB_LEN; i++) begin
            pulse(5'(i), 6'(i), c);
            wait_n(1);
        end
        check("rewarm_reads", rd_total - rd0, 0);
        check("rewarm_busy", 32'(Busy), 0);
        mem_mode = 2'd0;
        issue(5'd12, 6'h21, 1'b0);
        wait_n(70);
        check("rewarm_reads_run", rd_total - rd0, TB_LEN);

        // Make DecodedBit 1, then reset in the middle of a traceback.
        mem_mode = 2'd1;
        issue(5'd15, 6'h0C, 1'b1);
        wait_n(70);
        pulse(5'd8, 6'h2F, c);
        wait_n(15);
        @(posedge Clock1);
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(Busy), 0);
        check("mid_rst_rden", 32'(MemRdEn), 0);
        check("mid_rst_addr", 32'(MemRdAddr), 0);
        check("mid_rst_valid", 32'(DecodeValid), 0);
        check("mid_rst_bit", 32'(DecodedBit), 0);
        check("mid_rst_overrun", 32'(TbOverrun), 0);
        wait_n(3);
        Reset = 1'b1;
        wait_n(5);
        check("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
